aq_div_seq: RTL and testbench
=============================

# aq_div_seq

Sequencer for the restoring signed divider that owns the read/write side of the 64-bit AQ shift register. It loads the dividend into AQ and runs one shift/subtract step per cycle, reading AQ from the shared tristate bus and writing the next value back. It then sign-corrects and presents the quotient and remainder. It sits between the multdiv top level and the AQ register instance.

## Interface
- WIDTH, 32, operand width; AQ is 2*WIDTH bits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- ctrl_DIV  in  1  start pulse, sampled in IDLE only
- data_operandA  in  WIDTH  dividend, two's complement, sampled with ctrl_DIV
- data_operandB  in  WIDTH  divisor, two's complement, sampled with ctrl_DIV
- aq_d  out  2*WIDTH  next AQ value to the register
- aq_we  out  1  AQ write enable
- aq_oe  out  1  AQ output enable; drives the AQ bus
- aq_q  in  2*WIDTH  AQ tristate bus; valid only while aq_oe=1
- data_quotient  out  WIDTH  signed quotient
- data_remainder  out  WIDTH  signed remainder, sign of dividend
- data_exception  out  1  divide by zero
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE

## Operation
- States and transitions:
  - IDLE -> LOAD when ctrl_DIV=1.
  - LOAD -> DONE if divisor=0, else ITER.
  - ITER stays for WIDTH cycles, then -> FIX.
  - FIX -> DONE -> IDLE.
- On the accepting edge, latch sA=A[31], sB=B[31], |A| and |B|. Both absolute values are unsigned WIDTH bits, so |-2^31| = 0x80000000.
- LOAD: aq_d={0,|A|}, aq_we=1, aq_oe=0.
- ITER: aq_oe=1 and aq_we=1 in the same cycle.
  - s = aq_q<<1; d = {0,s[63:32]} - {0,|B|} (33-bit).
  - d[32]=0: aq_d={d[31:0], s[31:1], 1}.
  - Otherwise: aq_d=s.
  - Iteration counter runs 0..WIDTH-1.
- FIX: aq_oe=1, aq_we=0.
  - Quotient q=aq_q[31:0], negated if sA^sB.
  - Remainder r=aq_q[63:32], negated if sA.
  - Both are registered into the outputs.
- DONE: data_resultRDY=1 for one cycle.
  - On the divide-by-zero path, data_exception=1 and quotient/remainder are 0.
- Results and exception hold until the next start is accepted; accepting a start clears exception.
- ctrl_DIV is ignored while busy=1.
- Overflow -2^31 / -1 gives quotient 0x80000000 and remainder 0, with no exception (wrap).
- aq_q is never sampled while aq_oe=0; the bus is high-Z there.
- aq_oe and aq_we are both 0 in IDLE, DONE and reset.
- Reset values:
  - All outputs 0, state IDLE, counter 0.
  - Reset mid-operation aborts with no data_resultRDY.
  - The AQ register contents are not cleared by this block.

## Timing
- Start accepted at edge k.
  - LOAD in cycle k+1, ITER in k+2..k+WIDTH+1, FIX in k+WIDTH+2.
  - data_resultRDY high in cycle k+WIDTH+3 (35 cycles for WIDTH=32).
- Divide by zero: LOAD in k+1, data_resultRDY in k+2.
- Each ITER write lands at the end of its cycle; the next ITER reads the updated bus (single-cycle loop through the AQ register).
- A new start is accepted in the IDLE cycle after DONE, at the earliest.

## Structure
- Shared package multdiv_pkg:
  - state enum {IDLE, LOAD, ITER, FIX, DONE}
  - WIDTH default 32
  - ITER_CNT_W = clog2(WIDTH)
- Sub-module aq_div_step: combinational shift/subtract from aq_q and divisor to aq_d. Reused by the radix-2 divider variants.
- The AQ register is instantiated at the multdiv top level, not inside this block.

## Test plan
- 100 / 7 -> quotient 14, remainder 2, data_resultRDY exactly 35 cycles after the start edge, exception 0.
- -100 / 7 -> quotient -14 (0xFFFFFFF2), remainder -2. 100 / -7 -> quotient -14, remainder 2.
- 5 / 0 -> exception 1, quotient 0, remainder 0, data_resultRDY at cycle 2, aq_oe never asserted.
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, exception 0.
- Reset low during iteration 10:
  - Immediately busy=0, aq_we=0, aq_oe=0, outputs 0.
  - No data_resultRDY.
  - A following 9 / 3 returns 3 r 0.
- ctrl_DIV pulsed at cycles 5 and 20 of a running 7 / 2 -> ignored. Single result 3 r 1 with one RDY pulse. Checker confirms aq_q is only sampled with aq_oe=1.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the multiply/divide datapath sequencers.
// Also holds small two's-complement helpers used around the divider core.
package multdiv_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } state_t;

  // The magnitude of the most negative value stays 2^(WIDTH-1) because it is read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/aq_div_seq_if.sv
// Bundle between the multdiv top level, the divider sequencer and the AQ register.
// The sequencer uses the slave view; the top level / AQ side uses the master view.
interface aq_div_seq_if #(
  parameter int WIDTH = multdiv_pkg::WIDTH
);
  logic                 ctrl_DIV;
  logic [WIDTH-1:0]     data_operandA;
  logic [WIDTH-1:0]     data_operandB;
  logic [2*WIDTH-1:0]   aq_d;
  logic                 aq_we;
  logic                 aq_oe;
  logic [2*WIDTH-1:0]   aq_q;
  logic [WIDTH-1:0]     data_quotient;
  logic [WIDTH-1:0]     data_remainder;
  logic                 data_exception;
  logic                 data_resultRDY;
  logic                 busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB, aq_q,
    input  aq_d, aq_we, aq_oe, data_quotient, data_remainder,
           data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB, aq_q,
    output aq_d, aq_we, aq_oe, data_quotient, data_remainder,
           data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/aq_div_step.sv
// One restoring-division step: shift AQ left, trial-subtract the divisor from the
// upper half, keep the difference and set the quotient bit when it does not borrow.
module aq_div_step
  import multdiv_pkg::*;
(
  input  logic [2*WIDTH-1:0] aq_q,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] aq_d
);

  logic [2*WIDTH-1:0] s;
  logic [WIDTH:0]     d;

  always_comb begin
    s = aq_q << 1;
    d = {1'b0, s[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    if (!d[WIDTH]) begin
      aq_d = {d[WIDTH-1:0], s[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, 1'b1}};
    end else begin
      aq_d = s;
    end
  end

endmodule

// File: rtl/aq_div_seq.sv
// Sequencer for the restoring signed divider: loads |A| into the external AQ register,
// iterates WIDTH shift/subtract steps over the AQ bus, then sign-corrects the result.
module aq_div_seq
  import multdiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  aq_div_seq_if.slave bus
);

  state_t                  state;
  logic [ITER_CNT_W-1:0]   cnt;
  logic                    sa;
  logic                    sb;
  logic [WIDTH-1:0]        abs_a;
  logic [WIDTH-1:0]        abs_b;
  logic                    we_reg;
  logic                    oe_reg;
  logic                    rdy_reg;
  logic                    exc_reg;
  logic [WIDTH-1:0]        quo_reg;
  logic [WIDTH-1:0]        rem_reg;
  logic [2*WIDTH-1:0]      step_d;

  aq_div_step u_step (
    .aq_q    (bus.aq_q),
    .divisor (abs_b),
    .aq_d    (step_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      abs_a   <= '0;
      abs_b   <= '0;
      we_reg  <= 1'b0;
      oe_reg  <= 1'b0;
      rdy_reg <= 1'b0;
      exc_reg <= 1'b0;
      quo_reg <= '0;
      rem_reg <= '0;
    end else begin
      rdy_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ctrl_DIV) begin
            state   <= LOAD;
            sa      <= bus.data_operandA[WIDTH-1];
            sb      <= bus.data_operandB[WIDTH-1];
            abs_a   <= abs_val(bus.data_operandA);
            abs_b   <= abs_val(bus.data_operandB);
            exc_reg <= 1'b0;
            we_reg  <= 1'b1;
            oe_reg  <= 1'b0;
          end
        end
        LOAD: begin
          if (abs_b == '0) begin
            state   <= DONE;
            exc_reg <= 1'b1;
            quo_reg <= '0;
            rem_reg <= '0;
            rdy_reg <= 1'b1;
            we_reg  <= 1'b0;
          end else begin
            state  <= ITER;
            cnt    <= '0;
            oe_reg <= 1'b1;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == ITER_CNT_W'(WIDTH - 1)) begin
            state  <= FIX;
            we_reg <= 1'b0;
          end
        end
        FIX: begin
          // Remainder follows the dividend's sign; quotient the XOR of both signs.
          quo_reg <= cond_neg(bus.aq_q[WIDTH-1:0], sa ^ sb);
          rem_reg <= cond_neg(bus.aq_q[2*WIDTH-1:WIDTH], sa);
          rdy_reg <= 1'b1;
          oe_reg  <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ITER feeds the AQ register through the step logic in a single-cycle loop.
  assign bus.aq_d           = (state == ITER) ? step_d : {{WIDTH{1'b0}}, abs_a};
  assign bus.aq_we          = we_reg;
  assign bus.aq_oe          = oe_reg;
  assign bus.data_quotient  = quo_reg;
  assign bus.data_remainder = rem_reg;
  assign bus.data_exception = exc_reg;
  assign bus.data_resultRDY = rdy_reg;
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_aq_div_seq.sv
// Self-checking bench for aq_div_seq with a behavioural AQ register on the shared bus.
// Expected results go into a scoreboard at start time and are popped on data_resultRDY.
module tb_aq_div_seq;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } exp_t;

  // Pattern placed on aq_q whenever aq_oe is low, standing in for a floating bus.
  localparam logic [63:0] BUS_FLOAT = 64'hA5A5_5A5A_C3C3_3C3C;

  logic        clk;
  logic        reset;
  logic [63:0] aq_reg;
  exp_t        sb_q[$];
  int          checks;
  int          errors;
  int          rdy_seen;
  int          oe_cycles;

  aq_div_seq_if bus ();

  aq_div_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.aq_we) aq_reg <= bus.aq_d;
  end

  assign bus.aq_q = bus.aq_oe ? aq_reg : BUS_FLOAT;

  // Monitor: result scoreboard plus bus-enable sanity, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.aq_oe) oe_cycles++;
      checks++;
      if ((bus.aq_oe || bus.aq_we) && !bus.busy) begin
        errors++;
        $display("FAIL bus_enable_idle: oe=%0b we=%0b busy=%0b required oe=0 we=0 when idle",
                 bus.aq_oe, bus.aq_we, bus.busy);
      end
      if (bus.data_resultRDY) begin
        rdy_seen++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rdy: got data_resultRDY=1 required no pending result");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if ({bus.data_quotient, bus.data_remainder, bus.data_exception} !== {e.q, e.r, e.e}) begin
            errors++;
            $display("FAIL result: got q=%h r=%h exc=%0b required q=%h r=%h exc=%0b",
                     bus.data_quotient, bus.data_remainder, bus.data_exception, e.q, e.r, e.e);
          end
        end
      end
    end
  end

  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      e = 1'b0;
    end
  endtask

  // Starts one division; p1/p2 are cycle offsets at which a stray start is pulsed.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ee,
                         input int lat_exp, input int p1, input int p2, input string name);
    int   n;
    exp_t e;
    e.q = eq; e.r = er; e.e = ee;
    sb_q.push_back(e);
    @(negedge clk);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk); #1;
    bus.ctrl_DIV = 1'b0;
    n = 1;
    while (!bus.data_resultRDY && n < 100) begin
      bus.ctrl_DIV = (n == p1 || n == p2);
      if (bus.ctrl_DIV) begin
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.ctrl_DIV = 1'b0;
    checks++;
    if (n != lat_exp) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, n, lat_exp);
    end
    $display("txn %s: A=%0d B=%0d -> q=%0d r=%0d exc=%0b after %0d cycles", name,
             $signed(a), $signed(b), $signed(bus.data_quotient), $signed(bus.data_remainder),
             bus.data_exception, n);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset             = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.aq_we, bus.aq_oe, bus.data_resultRDY, bus.data_exception} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/we/oe/rdy/exc=%b required 00000",
               {bus.busy, bus.aq_we, bus.aq_oe, bus.data_resultRDY, bus.data_exception});
    end
    checks++;
    if ({bus.data_quotient, bus.data_remainder} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: got q=%h r=%h required 0 0", bus.data_quotient, bus.data_remainder);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("txn reset: outputs checked while reset low");
  endtask

  task automatic test_basic;
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35, 0, 0, "pos_pos");
    run_div(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35, 0, 0, "neg_pos");
    run_div(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 35, 0, 0, "pos_neg");
  endtask

  task automatic test_div_zero;
    int oe_before;
    oe_before = oe_cycles;
    run_div(32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 2, 0, 0, "div_zero");
    checks++;
    if (oe_cycles != oe_before) begin
      errors++;
      $display("FAIL div_zero_oe: got %0d aq_oe cycles required 0", oe_cycles - oe_before);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.data_exception !== 1'b1) begin
      errors++;
      $display("FAIL exception_hold: got %0b required 1", bus.data_exception);
    end
  endtask

  task automatic test_overflow;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 35, 0, 0, "overflow");
  endtask

  task automatic test_reset_mid;
    int rdy_before;
    int n;
    @(negedge clk);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd7;
    @(posedge clk); #1;
    bus.ctrl_DIV = 1'b0;
    n = 1;
    while (n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    rdy_before = rdy_seen;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.aq_we, bus.aq_oe, bus.data_resultRDY, bus.data_exception} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_ctrl: got busy/we/oe/rdy/exc=%b required 00000",
               {bus.busy, bus.aq_we, bus.aq_oe, bus.data_resultRDY, bus.data_exception});
    end
    checks++;
    if ({bus.data_quotient, bus.data_remainder} !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_data: got q=%h r=%h required 0 0", bus.data_quotient, bus.data_remainder);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (rdy_seen != rdy_before) begin
      errors++;
      $display("FAIL reset_mid_rdy: got %0d pulses required 0", rdy_seen - rdy_before);
    end
    $display("txn reset_mid: aborted 100/7 at iteration 10");
    run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 35, 0, 0, "after_reset");
  endtask

  task automatic test_ignore_start;
    int rdy_before;
    rdy_before = rdy_seen;
    run_div(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 35, 5, 20, "ignore_start");
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rdy_seen - rdy_before != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got %0d pulses busy=%0b required 1 pulse busy=0",
               rdy_seen - rdy_before, bus.busy);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 3) b = -b;
      model(a, b, q, r, e);
      run_div(a, b, q, r, e, e ? 2 : 35, 0, 0, "random");
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rdy_seen  = 0;
    oe_cycles = 0;
    aq_reg    = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_ignore_start();
    test_random();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
